// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 matrix keypad scanner with a 2-flop row synchroniser, press/release
// debounce and one-cycle one-hot key pulses. Define KEYPAD_AUTOREPEAT_EN for held-key auto-repeat.
module keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [0:9] key_pulse,
  output logic       key_star,
  output logic       key_hash,
  output logic       key_valid,
  output logic [3:0] key_code
);
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_scanner: illegal parameter value");
  end

  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, PRESSED = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [3:0]        sync1_q, rows_s_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [1:0]        col_q, col_d;
  logic [3:0]        pat_q, pat_d;
  logic              valid_q, valid_d;
  logic [0:9]        pulse_q, pulse_d;
  logic              star_q, star_d, hash_q, hash_d;
  logic [3:0]        code_q, code_d;
  logic              emit, one_low;
  logic [3:0]        low, emit_code;
  logic [1:0]        next_col;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);
  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_armed_q, rep_armed_d;
`endif

  // Key code from the latched one-low row pattern and the column being held.
  function automatic logic [3:0] key_of(input logic [3:0] pat, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    case (pat)
      4'b1110: code = 4'd1 + {2'd0, col};
      4'b1101: code = 4'd4 + {2'd0, col};
      4'b1011: code = 4'd7 + {2'd0, col};
      4'b0111: code = (col == 2'd0) ? 4'd10 : ((col == 2'd1) ? 4'd0 : 4'd11);
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  assign low       = ~rows_s_q;
  assign one_low   = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign next_col  = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
  assign emit_code = key_of(pat_q, col_q);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    deb_d   = deb_q;
    col_d   = col_q;
    pat_d   = pat_q;
    emit    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d       = rep_q;
    rep_armed_d = rep_armed_q;
`endif
    case (state_q)
      SCAN: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (one_low) begin
            pat_d   = rows_s_q;
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = next_col;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rows_s_q == pat_q) begin
          if (deb_q == DEB_LAST) begin
            emit    = 1'b1;
            deb_d   = '0;
            state_d = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d       = '0;
            rep_armed_d = 1'b0;
`endif
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d   = '0;
          col_d   = next_col;
          state_d = SCAN;
        end
      end
      PRESSED: begin
        // deb_q is reused here as the release (all rows high) counter.
        if (rows_s_q == 4'b1111) begin
          if (deb_q == DEB_LAST) begin
            deb_d   = '0;
            col_d   = next_col;
            state_d = SCAN;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (rows_s_q == pat_q) begin
          if (rep_q == (rep_armed_q ? RATE_LAST : DELAY_LAST)) begin
            emit        = 1'b1;
            rep_d       = '0;
            rep_armed_d = 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end else begin
          rep_d = '0;
        end
`endif
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    valid_d = emit;
    star_d  = emit && (emit_code == 4'd10);
    hash_d  = emit && (emit_code == 4'd11);
    code_d  = emit ? emit_code : code_q;
    pulse_d = '0;
    for (int i = 0; i < 10; i++) pulse_d[i] = emit && (emit_code == 4'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SCAN;
      sync1_q  <= 4'b1111;
      rows_s_q <= 4'b1111;
      slot_q   <= '0;
      deb_q    <= '0;
      col_q    <= 2'd0;
      pat_q    <= 4'b1111;
      valid_q  <= 1'b0;
      pulse_q  <= '0;
      star_q   <= 1'b0;
      hash_q   <= 1'b0;
      code_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= row_n;
      rows_s_q <= sync1_q;
      slot_q   <= slot_d;
      deb_q    <= deb_d;
      col_q    <= col_d;
      pat_q    <= pat_d;
      valid_q  <= valid_d;
      pulse_q  <= pulse_d;
      star_q   <= star_d;
      hash_q   <= hash_d;
      code_q   <= code_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q       <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`endif

  always_comb begin
    case (col_q)
      2'd0:    col_n = 3'b110;
      2'd1:    col_n = 3'b101;
      default: col_n = 3'b011;
    endcase
  end

  assign key_valid = valid_q;
  assign key_pulse = pulse_q;
  assign key_star  = star_q;
  assign key_hash  = hash_q;
  assign key_code  = code_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model driven from a layout table, a pulse
// monitor, and per-scenario tasks checking codes, pulse shapes and press-to-pulse latency.
module tb_keypad_scanner;
  localparam int SCAN_DIV  = 4;
  localparam int DEB       = 8;
  localparam int REP_DELAY = 40;
  localparam int REP_RATE  = 10;
  localparam int LAT_MAX   = 3 * SCAN_DIV + DEB + 3;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HOLD = 30;
`else
  localparam int HOLD = 60;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [0:9] key_pulse;
  logic       key_star, key_hash, key_valid;
  logic [3:0] key_code;

  logic [3:0][2:0] held = '0;
  int layout [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [3:0]  obs_code_q[$];
  logic [11:0] obs_vec_q[$];
  int          obs_cyc_q[$];
  logic [3:0]  exp_q[$];
  int          t0_q[$];

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(REP_DELAY), .REPEAT_RATE(REP_RATE)
  ) dut (
    .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n), .key_pulse(key_pulse),
    .key_star(key_star), .key_hash(key_hash), .key_valid(key_valid), .key_code(key_code)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Matrix model: a held key pulls its row low while its column is driven low.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (held[r][c] && col_n[c] === 1'b0) row_n[r] = 1'b0;
  end

  function automatic void set_key(input int code, input logic v);
    for (int p = 0; p < 12; p++)
      if (layout[p] == code) held[p / 3][p % 3] = v;
  endfunction

  function automatic logic [11:0] exp_vec(input int code);
    logic [0:9] p;
    p = '0;
    if (code < 10) p[code] = 1'b1;
    return {p, code == 10, code == 11};
  endfunction

  function automatic void clear_obs();
    obs_code_q.delete();
    obs_vec_q.delete();
    obs_cyc_q.delete();
  endfunction

  // Monitor: column drive and pulse-line invariants, and capture of every accepted key.
  always @(negedge clk) begin
    if (!reset) begin
      compared++;
      if ($countones(col_n) != 2 || $isunknown(col_n)) begin
        mismatched++;
        $display("FAIL col_onehot: col_n=%b, want exactly one low bit", col_n);
      end
      compared++;
      if ($countones({key_pulse, key_star, key_hash}) != (key_valid ? 1 : 0)) begin
        mismatched++;
        $display("FAIL pulse_exclusive: valid=%b pulse=%b star=%b hash=%b, want one line high iff valid",
                 key_valid, key_pulse, key_star, key_hash);
      end
      if (key_valid === 1'b1) begin
        obs_code_q.push_back(key_code);
        obs_vec_q.push_back({key_pulse, key_star, key_hash});
        obs_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic test_reset();
    logic [2:0] one;
    reset = 1'b1;
    held  = '0;
    repeat (3) @(negedge clk);
    compared++;
    if (col_n !== 3'b110 || key_valid !== 1'b0 || key_pulse !== 10'd0 || key_star !== 1'b0 ||
        key_hash !== 1'b0 || key_code !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_values: col_n=%b valid=%b pulse=%b star=%b hash=%b code=%0d, want 110/0/0/0/0/0",
               col_n, key_valid, key_pulse, key_star, key_hash, key_code);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      one = 3'b001 << ((i / SCAN_DIV) % 3);
      compared++;
      if (col_n !== ~one) begin
        mismatched++;
        $display("FAIL scan_sequence[%0d]: col_n=%b, want %b", i, col_n, ~one);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_key5();
    int t0, lat;
    logic [2:0] seen;
    clear_obs();
    set_key(5, 1'b1);
    t0 = cyc;
    repeat (HOLD) @(negedge clk);
    set_key(5, 1'b0);
    repeat (DEB + 12) @(negedge clk);
    compared++;
    if (obs_code_q.size() != 1) begin
      mismatched++;
      $display("FAIL key5_count: %0d pulses, want 1", obs_code_q.size());
    end else begin
      lat = obs_cyc_q[0] - t0;
      compared++;
      if (obs_code_q[0] !== 4'd5) begin
        mismatched++;
        $display("FAIL key5_code: %0d, want 5", obs_code_q[0]);
      end
      compared++;
      if (obs_vec_q[0] !== exp_vec(5)) begin
        mismatched++;
        $display("FAIL key5_lines: %b, want %b", obs_vec_q[0], exp_vec(5));
      end
      compared++;
      if (lat < DEB || lat > LAT_MAX) begin
        mismatched++;
        $display("FAIL key5_latency: %0d cycles, want %0d..%0d", lat, DEB, LAT_MAX);
      end
    end
    compared++;
    if (key_code !== 4'd5) begin
      mismatched++;
      $display("FAIL key5_code_hold: %0d, want 5", key_code);
    end
    seen = 3'b000;
    repeat (3 * SCAN_DIV) begin
      seen |= ~col_n;
      @(negedge clk);
    end
    compared++;
    if (seen !== 3'b111) begin
      mismatched++;
      $display("FAIL key5_scan_resumes: columns seen %b, want 111", seen);
    end
  endtask

  task automatic test_bounce();
    int t0, lat;
    clear_obs();
    for (int s = 0; s < 6; s++) begin
      set_key(2, 1'b1);
      repeat ($urandom_range(1, DEB - 3)) @(negedge clk);
      set_key(2, 1'b0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    compared++;
    if (obs_code_q.size() != 0) begin
      mismatched++;
      $display("FAIL bounce_quiet: %0d pulses while bouncing, want 0", obs_code_q.size());
    end
    set_key(2, 1'b1);
    t0 = cyc;
    repeat (HOLD) @(negedge clk);
    set_key(2, 1'b0);
    repeat (DEB + 12) @(negedge clk);
    compared++;
    if (obs_code_q.size() != 1) begin
      mismatched++;
      $display("FAIL bounce_count: %0d pulses, want 1", obs_code_q.size());
    end else begin
      lat = obs_cyc_q[0] - t0;
      compared++;
      if (obs_code_q[0] !== 4'd2 || obs_vec_q[0] !== exp_vec(2)) begin
        mismatched++;
        $display("FAIL bounce_key: code %0d lines %b, want 2 / %b", obs_code_q[0], obs_vec_q[0], exp_vec(2));
      end
      compared++;
      if (lat < DEB || lat > LAT_MAX) begin
        mismatched++;
        $display("FAIL bounce_latency: %0d cycles, want %0d..%0d", lat, DEB, LAT_MAX);
      end
    end
  endtask

  task automatic test_ghost();
    int t0, lat;
    clear_obs();
    set_key(1, 1'b1);
    set_key(4, 1'b1);
    repeat (40) @(negedge clk);
    compared++;
    if (obs_code_q.size() != 0) begin
      mismatched++;
      $display("FAIL ghost_reject: %0d pulses with two rows low, want 0", obs_code_q.size());
    end
    set_key(4, 1'b0);
    t0 = cyc;
    repeat (LAT_MAX + 4) @(negedge clk);
    set_key(1, 1'b0);
    repeat (DEB + 12) @(negedge clk);
    compared++;
    if (obs_code_q.size() != 1) begin
      mismatched++;
      $display("FAIL ghost_count: %0d pulses after release of 4, want 1", obs_code_q.size());
    end else begin
      lat = obs_cyc_q[0] - t0;
      compared++;
      if (obs_code_q[0] !== 4'd1 || obs_vec_q[0] !== exp_vec(1)) begin
        mismatched++;
        $display("FAIL ghost_key: code %0d lines %b, want 1 / %b", obs_code_q[0], obs_vec_q[0], exp_vec(1));
      end
      compared++;
      if (lat < DEB || lat > LAT_MAX) begin
        mismatched++;
        $display("FAIL ghost_latency: %0d cycles, want %0d..%0d", lat, DEB, LAT_MAX);
      end
    end
  endtask

  task automatic test_star_hash();
    for (int k = 10; k <= 11; k++) begin
      clear_obs();
      set_key(k, 1'b1);
      repeat (HOLD) @(negedge clk);
      set_key(k, 1'b0);
      repeat (DEB + 12) @(negedge clk);
      compared++;
      if (obs_code_q.size() != 1) begin
        mismatched++;
        $display("FAIL cmd_count[%0d]: %0d pulses, want 1", k, obs_code_q.size());
      end else begin
        compared++;
        if (obs_code_q[0] !== 4'(k) || obs_vec_q[0] !== exp_vec(k)) begin
          mismatched++;
          $display("FAIL cmd_key[%0d]: code %0d lines %b, want %0d / %b", k, obs_code_q[0], obs_vec_q[0], k, exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    set_key(9, 1'b1);
    for (int i = 0; i < LAT_MAX + 2 && obs_code_q.size() == 0; i++) begin
      @(negedge clk);
      #1;
    end
    compared++;
    if (obs_code_q.size() != 1 || obs_code_q[0] !== 4'd9) begin
      mismatched++;
      $display("FAIL rst9_first: %0d pulses, want one with code 9", obs_code_q.size());
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (key_code !== 4'd0 || key_valid !== 1'b0 || col_n !== 3'b110) begin
      mismatched++;
      $display("FAIL rst9_cleared: code=%0d valid=%b col_n=%b, want 0/0/110", key_code, key_valid, col_n);
    end
    reset = 1'b0;
    clear_obs();
    for (int i = 0; i < LAT_MAX + 2 && obs_code_q.size() == 0; i++) begin
      @(negedge clk);
      #1;
    end
    repeat (5) @(negedge clk);
    set_key(9, 1'b0);
    repeat (DEB + 12) @(negedge clk);
    compared++;
    if (obs_code_q.size() != 1) begin
      mismatched++;
      $display("FAIL rst9_repress_count: %0d pulses after reset, want 1", obs_code_q.size());
    end else begin
      compared++;
      if (obs_code_q[0] !== 4'd9 || obs_vec_q[0] !== exp_vec(9)) begin
        mismatched++;
        $display("FAIL rst9_repress_key: code %0d lines %b, want 9 / %b", obs_code_q[0], obs_vec_q[0], exp_vec(9));
      end
    end
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int t0, lat, n_lo, n_hi, gap;
    clear_obs();
    set_key(9, 1'b1);
    t0 = cyc;
    repeat (100) @(negedge clk);
    set_key(9, 1'b0);
    repeat (DEB + 12) @(negedge clk);
    compared++;
    if (obs_code_q.size() == 0) begin
      mismatched++;
      $display("FAIL rep_none: 0 pulses while holding 9, want several");
    end else begin
      lat  = obs_cyc_q[0] - t0;
      n_lo = 1;
      n_hi = 1;
      for (int t = lat + REP_DELAY; t <= 102; t += REP_RATE) begin
        if (t < 100) n_lo++;
        n_hi++;
      end
      compared++;
      if (obs_code_q.size() < n_lo || obs_code_q.size() > n_hi) begin
        mismatched++;
        $display("FAIL rep_count: %0d pulses, want %0d..%0d", obs_code_q.size(), n_lo, n_hi);
      end
      for (int i = 0; i < obs_code_q.size(); i++) begin
        gap = (i == 0) ? 0 : obs_cyc_q[i] - obs_cyc_q[i - 1];
        compared++;
        if (obs_code_q[i] !== 4'd9 || obs_vec_q[i] !== exp_vec(9) ||
            (i == 1 && gap != REP_DELAY) || (i > 1 && gap != REP_RATE)) begin
          mismatched++;
          $display("FAIL rep_pulse[%0d]: code %0d gap %0d, want 9 with gap %0d", i, obs_code_q[i], gap,
                   (i == 1) ? REP_DELAY : REP_RATE);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    int code, lat;
    clear_obs();
    exp_q.delete();
    t0_q.delete();
    for (int n = 0; n < 8; n++) begin
      code = $urandom_range(0, 11);
      exp_q.push_back(4'(code));
      set_key(code, 1'b1);
      t0_q.push_back(cyc);
      repeat ($urandom_range(LAT_MAX + 2, 35)) @(negedge clk);
      set_key(code, 1'b0);
      repeat (DEB + 12 + $urandom_range(0, 8)) @(negedge clk);
    end
    compared++;
    if (obs_code_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL rand_count: %0d pulses, want %0d", obs_code_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        lat = obs_cyc_q[i] - t0_q[i];
        compared++;
        if (obs_code_q[i] !== exp_q[i] || obs_vec_q[i] !== exp_vec(int'(exp_q[i])) || lat < DEB || lat > LAT_MAX) begin
          mismatched++;
          $display("FAIL rand_key[%0d]: code %0d lines %b latency %0d, want %0d / %b / %0d..%0d", i,
                   obs_code_q[i], obs_vec_q[i], lat, exp_q[i], exp_vec(int'(exp_q[i])), DEB, LAT_MAX);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_key5();
    test_bounce();
    test_ghost();
    test_star_hash();
    test_reset_mid();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
